ika87ad_mcseq: RTL and testbench

// - Microcode sequencer for the IKA87AD core: owns the micro-PC (MPC) and issues reads to the microcode ROM.
// - Presents each fetched 18-bit microword to the datapath for one execute cycle.
// - Decodes the 2-bit NEXT field to continue, run a bus cycle, or end the instruction and request the next opcode.
// - Sits between the opcode decoder/bus unit and the microcode ROM (1-cycle registered read, gated by read tick).

---
 rtl/ika87ad_mcseq.sv | 188 ++++++++++++++++++
 tb/tb_ika87ad_mcseq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ika87ad_mcseq.sv
// ika87ad_mcseq -- microcode sequencer for the IKA87AD core.
//
// Owns the micro-PC (MPC), issues reads to the registered microcode ROM,
// presents each fetched microword to the datapath for one execute cycle and
// dispatches on its 2-bit NEXT field (word[1:0]):
//   00 CONT : MPC+1, read next word
//   01 RD3  : bus read, then MPC+1
//   10 WR   : bus write, then MPC+1
//   11 RD4  : end of instruction, request next opcode
//
// Optional feature: define IKA87AD_MCSEQ_SKIP_EN to let an opcode flagged
// with i_SKIP be dropped in FETCH without touching the ROM (o_SKIP_DONE
// pulses). Undefined: i_SKIP is ignored and o_SKIP_DONE is tied 0.
//
// Ports:
//   i_CLK, i_RST (async, active-high), i_CEN (clock enable)
//   o_FETCH_REQ, i_OPCODE_VALID, i_OPCODE_ADDR, i_SKIP, o_SKIP_DONE : decoder side
//   o_MCROM_READ_TICK, o_MCROM_ADDR, i_MCROM_DATA                   : ROM side
//   o_MC_EXEC, o_MC_WORD                                            : datapath side
//   o_BUS_REQ, o_BUS_WR, i_BUS_ACK                                  : bus unit side
//   o_MPC_WRAP : sticky, MPC incremented past all-ones
module ika87ad_mcseq #(
  parameter int MPC_W = 8,
  parameter int MC_W  = 18
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_CEN,
  output logic             o_FETCH_REQ,
  input  logic             i_OPCODE_VALID,
  input  logic [MPC_W-1:0] i_OPCODE_ADDR,
  input  logic             i_SKIP,
  output logic             o_SKIP_DONE,
  output logic             o_MCROM_READ_TICK,
  output logic [MPC_W-1:0] o_MCROM_ADDR,
  input  logic [MC_W-1:0]  i_MCROM_DATA,
  output logic             o_MC_EXEC,
  output logic [MC_W-1:0]  o_MC_WORD,
  output logic             o_BUS_REQ,
  output logic             o_BUS_WR,
  input  logic             i_BUS_ACK,
  output logic             o_MPC_WRAP
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ROMRD   = 2'd1,
    ST_EXEC    = 2'd2,
    ST_BUSWAIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NX_CONT = 2'b00,
    NX_RD3  = 2'b01,
    NX_WR   = 2'b10,
    NX_RD4  = 2'b11
  } next_t;

  state_t           state;
  logic [MPC_W-1:0] mpc;
  logic [MC_W-1:0]  mc_word;
  logic             fetch_req;
  logic             tick_q;
  logic             exec_q;
  logic             bus_req;
  logic             bus_wr;
  logic             mpc_wrap;
  next_t            next_code;
  logic             accept;
  logic [MPC_W-1:0] mpc_inc;
  logic             mpc_at_max;

`ifdef IKA87AD_MCSEQ_SKIP_EN
  logic skip_hit;
  logic skip_q;
`endif

  always_comb begin
    next_code  = next_t'(i_MCROM_DATA[1:0]);
    mpc_inc    = mpc + 1'b1;
    mpc_at_max = &mpc;
`ifdef IKA87AD_MCSEQ_SKIP_EN
    skip_hit   = i_OPCODE_VALID & i_SKIP;
    accept     = i_OPCODE_VALID & ~i_SKIP;
`else
    accept     = i_OPCODE_VALID;
`endif
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= ST_FETCH;
      mpc       <= '0;
      mc_word   <= '0;
      fetch_req <= 1'b0;
      tick_q    <= 1'b0;
      exec_q    <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      mpc_wrap  <= 1'b0;
`ifdef IKA87AD_MCSEQ_SKIP_EN
      skip_q    <= 1'b0;
`endif
    end else if (i_CEN) begin
      // Single-cycle strobes drop on every enabled edge unless re-armed below.
      tick_q <= 1'b0;
      exec_q <= 1'b0;
`ifdef IKA87AD_MCSEQ_SKIP_EN
      skip_q <= 1'b0;
`endif
      case (state)
        ST_FETCH: begin
`ifdef IKA87AD_MCSEQ_SKIP_EN
          skip_q <= skip_hit;
`endif
          if (accept) begin
            mpc       <= i_OPCODE_ADDR;
            fetch_req <= 1'b0;
            tick_q    <= 1'b1;
            state     <= ST_ROMRD;
          end else begin
            fetch_req <= 1'b1;
          end
        end

        ST_ROMRD: begin
          state <= ST_EXEC;
        end

        // ROM data is valid here; capture it and dispatch on its NEXT field.
        // The word and its exec strobe become visible together after this edge.
        ST_EXEC: begin
          mc_word <= i_MCROM_DATA;
          exec_q  <= 1'b1;
          case (next_code)
            NX_CONT: begin
              mpc    <= mpc_inc;
              if (mpc_at_max) mpc_wrap <= 1'b1;
              tick_q <= 1'b1;
              state  <= ST_ROMRD;
            end
            NX_RD3, NX_WR: begin
              bus_req <= 1'b1;
              bus_wr  <= (next_code == NX_WR);
              state   <= ST_BUSWAIT;
            end
            NX_RD4: begin
              fetch_req <= 1'b1;
              state     <= ST_FETCH;
            end
          endcase
        end

        ST_BUSWAIT: begin
          if (i_BUS_ACK) begin
            bus_req <= 1'b0;
            bus_wr  <= 1'b0;
            mpc     <= mpc_inc;
            if (mpc_at_max) mpc_wrap <= 1'b1;
            tick_q  <= 1'b1;
            state   <= ST_ROMRD;
          end
        end

        default: state <= ST_FETCH;
      endcase
    end
  end

  // Strobe registers hold across disabled cycles, so gate them with i_CEN to
  // keep each pulse exactly one enabled cycle wide.
  assign o_MCROM_READ_TICK = tick_q & i_CEN;
  assign o_MC_EXEC         = exec_q & i_CEN;
  assign o_MCROM_ADDR      = mpc;
  assign o_MC_WORD         = mc_word;
  assign o_FETCH_REQ       = fetch_req;
  assign o_BUS_REQ         = bus_req;
  assign o_BUS_WR          = bus_wr;
  assign o_MPC_WRAP        = mpc_wrap;

`ifdef IKA87AD_MCSEQ_SKIP_EN
  assign o_SKIP_DONE = skip_q & i_CEN;
`else
  // Skip feature absent: the flag is read but never acted upon.
  assign o_SKIP_DONE = i_SKIP & 1'b0;
`endif

endmodule

// File: tb/tb_ika87ad_mcseq.sv
// tb_ika87ad_mcseq -- directed bench for ika87ad_mcseq with a registered
// microcode ROM model (1-cycle read, gated by the read tick).
module tb_ika87ad_mcseq;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        fetch_req;
  logic        op_valid;
  logic [7:0]  op_addr;
  logic        skip;
  logic        skip_done;
  logic        rd_tick;
  logic [7:0]  rom_addr;
  logic [17:0] rom_q;
  logic        mc_exec;
  logic [17:0] mc_word;
  logic        bus_req;
  logic        bus_wr;
  logic        bus_ack;
  logic        mpc_wrap;

  logic [17:0] rom [256];

  int unsigned n_cmp;
  int unsigned n_err;

  ika87ad_mcseq #(.MPC_W(8), .MC_W(18)) dut (
    .i_CLK             (clk),
    .i_RST             (rst),
    .i_CEN             (cen),
    .o_FETCH_REQ       (fetch_req),
    .i_OPCODE_VALID    (op_valid),
    .i_OPCODE_ADDR     (op_addr),
    .i_SKIP            (skip),
    .o_SKIP_DONE       (skip_done),
    .o_MCROM_READ_TICK (rd_tick),
    .o_MCROM_ADDR      (rom_addr),
    .i_MCROM_DATA      (rom_q),
    .o_MC_EXEC         (mc_exec),
    .o_MC_WORD         (mc_word),
    .o_BUS_REQ         (bus_req),
    .o_BUS_WR          (bus_wr),
    .i_BUS_ACK         (bus_ack),
    .o_MPC_WRAP        (mpc_wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rd_tick) rom_q <= rom[rom_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned k;
    int unsigned ticks;
    int unsigned execs;
    logic        done;
    logic [17:0] exp_w [3];

    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) rom[i] = 18'h0;
    rom[8'h40] = 18'h12345;  // RD3
    rom[8'h41] = 18'h0ABCF;  // RD4
    rom[8'h10] = 18'h3FFF0;  // CONT
    rom[8'h11] = 18'h1111A;  // WR
    rom[8'h12] = 18'h22223;  // RD4
    rom[8'hFF] = 18'h15550;  // CONT (wraps)
    rom[8'h00] = 18'h0AAA7;  // RD4
    rom[8'h80] = 18'h00004;  // CONT
    rom[8'h81] = 18'h00008;  // CONT
    rom[8'h82] = 18'h0000F;  // RD4
    exp_w[0] = 18'h00004;
    exp_w[1] = 18'h00008;
    exp_w[2] = 18'h0000F;

    rst = 1'b1; cen = 1'b1; op_valid = 1'b0; op_addr = 8'h00;
    skip = 1'b0; bus_ack = 1'b0; rom_q = 18'h0;

    // ---- reset state ----
    step(); step();
    chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("rst_tick", {31'd0, rd_tick}, 32'd0);
    chk("rst_exec", {31'd0, mc_exec}, 32'd0);
    chk("rst_busreq", {31'd0, bus_req}, 32'd0);
    chk("rst_word", {14'd0, mc_word}, 32'd0);
    chk("rst_addr", {24'd0, rom_addr}, 32'd0);
    chk("rst_wrap", {31'd0, mpc_wrap}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_fetch_req", {31'd0, fetch_req}, 32'd1);

    // ---- opcode 0x40: RD3 then RD4 ----
    op_valid = 1'b1; op_addr = 8'h40;
    step();                                  // ROMRD
    op_valid = 1'b0;
    chk("op40_tick0", {31'd0, rd_tick}, 32'd1);
    chk("op40_addr0", {24'd0, rom_addr}, 32'h40);
    chk("op40_fetch_low", {31'd0, fetch_req}, 32'd0);
    step();                                  // EXEC
    chk("op40_exec_early", {31'd0, mc_exec}, 32'd0);
    step();                                  // BUSWAIT 1
    chk("op40_exec0", {31'd0, mc_exec}, 32'd1);
    chk("op40_word0", {14'd0, mc_word}, 32'h12345);
    chk("op40_busreq1", {31'd0, bus_req}, 32'd1);
    chk("op40_buswr1", {31'd0, bus_wr}, 32'd0);
    step();                                  // BUSWAIT 2
    chk("op40_busreq2", {31'd0, bus_req}, 32'd1);
    chk("op40_exec_drop", {31'd0, mc_exec}, 32'd0);
    step();                                  // BUSWAIT 3
    chk("op40_busreq3", {31'd0, bus_req}, 32'd1);
    chk("op40_buswr3", {31'd0, bus_wr}, 32'd0);
    bus_ack = 1'b1;
    step();                                  // ROMRD @41
    bus_ack = 1'b0;
    chk("op40_busreq_done", {31'd0, bus_req}, 32'd0);
    chk("op40_tick1", {31'd0, rd_tick}, 32'd1);
    chk("op40_addr1", {24'd0, rom_addr}, 32'h41);
    step();                                  // EXEC
    step();                                  // FETCH
    chk("op40_exec1", {31'd0, mc_exec}, 32'd1);
    chk("op40_word1", {14'd0, mc_word}, 32'h0ABCF);
    chk("op40_fetch_req", {31'd0, fetch_req}, 32'd1);
    step();
    chk("op40_idle_exec", {31'd0, mc_exec}, 32'd0);
    chk("op40_idle_tick", {31'd0, rd_tick}, 32'd0);

    // ---- opcode 0x10: CONT (spurious ack in EXEC), WR, RD4 ----
    op_valid = 1'b1; op_addr = 8'h10;
    step();                                  // ROMRD @10
    op_valid = 1'b0;
    step();                                  // EXEC
    bus_ack = 1'b1;
    step();                                  // ROMRD @11
    bus_ack = 1'b0;
    chk("op10_word0", {14'd0, mc_word}, 32'h3FFF0);
    chk("op10_spurious_busreq", {31'd0, bus_req}, 32'd0);
    chk("op10_tick1", {31'd0, rd_tick}, 32'd1);
    chk("op10_addr1", {24'd0, rom_addr}, 32'h11);
    step();                                  // EXEC
    step();                                  // BUSWAIT
    chk("op10_word1", {14'd0, mc_word}, 32'h1111A);
    chk("op10_busreq", {31'd0, bus_req}, 32'd1);
    chk("op10_buswr", {31'd0, bus_wr}, 32'd1);
    bus_ack = 1'b1;
    step();                                  // ROMRD @12
    bus_ack = 1'b0;
    chk("op10_buswr_clr", {31'd0, bus_wr}, 32'd0);
    chk("op10_addr2", {24'd0, rom_addr}, 32'h12);
    step();                                  // EXEC
    step();                                  // FETCH
    chk("op10_word2", {14'd0, mc_word}, 32'h22223);
    chk("op10_fetch_req", {31'd0, fetch_req}, 32'd1);

    // ---- opcode 0xFF: CONT wraps MPC to 0x00 ----
    op_valid = 1'b1; op_addr = 8'hFF;
    step();                                  // ROMRD @FF
    op_valid = 1'b0;
    chk("wrap_pre", {31'd0, mpc_wrap}, 32'd0);
    step();                                  // EXEC
    step();                                  // ROMRD @00
    chk("wrap_addr", {24'd0, rom_addr}, 32'h00);
    chk("wrap_flag", {31'd0, mpc_wrap}, 32'd1);
    step();                                  // EXEC
    step();                                  // FETCH
    chk("wrap_word", {14'd0, mc_word}, 32'h0AAA7);
    chk("wrap_fetch_req", {31'd0, fetch_req}, 32'd1);

    // ---- opcode 0x80: CONT chain with i_CEN toggling ----
    op_valid = 1'b1; op_addr = 8'h80;
    step();                                  // ROMRD @80
    op_valid = 1'b0;
    k = 0; ticks = 0; execs = 0; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      cen = (i % 2 == 0);
      #1;
      if (!cen) begin
        chk("cen_off_tick", {31'd0, rd_tick}, 32'd0);
        chk("cen_off_exec", {31'd0, mc_exec}, 32'd0);
      end else begin
        if (rd_tick) ticks++;
        if (mc_exec) begin
          execs++;
          if (k < 3) chk("cen_word", {14'd0, mc_word}, {14'd0, exp_w[k]});
          k++;
          if (mc_word[1:0] == 2'b11) done = 1'b1;
        end
      end
      step();
    end
    cen = 1'b1;
    #1;
    chk("cen_words", k, 32'd3);
    chk("cen_ticks", ticks, 32'd3);
    chk("cen_execs", execs, 32'd3);
    chk("cen_fetch_req", {31'd0, fetch_req}, 32'd1);
    chk("wrap_sticky", {31'd0, mpc_wrap}, 32'd1);

    // ---- reset in the middle of BUSWAIT ----
    step();
    op_valid = 1'b1; op_addr = 8'h40;
    step();                                  // ROMRD
    op_valid = 1'b0;
    step();                                  // EXEC
    step();                                  // BUSWAIT
    chk("midrst_busreq_pre", {31'd0, bus_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busreq", {31'd0, bus_req}, 32'd0);
    chk("midrst_tick", {31'd0, rd_tick}, 32'd0);
    chk("midrst_exec", {31'd0, mc_exec}, 32'd0);
    chk("midrst_wrap", {31'd0, mpc_wrap}, 32'd0);
    chk("midrst_word", {14'd0, mc_word}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("midrst_fetch_req", {31'd0, fetch_req}, 32'd1);
    step();
    chk("midrst_no_busreq", {31'd0, bus_req}, 32'd0);
    chk("midrst_no_tick", {31'd0, rd_tick}, 32'd0);

    // ---- opcode valid with skip flag ----
    op_valid = 1'b1; op_addr = 8'h12; skip = 1'b1;
    step();
    op_valid = 1'b0; skip = 1'b0;
`ifdef IKA87AD_MCSEQ_SKIP_EN
    chk("skip_done", {31'd0, skip_done}, 32'd1);
    chk("skip_no_tick", {31'd0, rd_tick}, 32'd0);
    chk("skip_addr", {24'd0, rom_addr}, 32'h00);
    chk("skip_fetch_req", {31'd0, fetch_req}, 32'd1);
    step();
    chk("skip_done_drop", {31'd0, skip_done}, 32'd0);
`else
    chk("noskip_done", {31'd0, skip_done}, 32'd0);
    chk("noskip_tick", {31'd0, rd_tick}, 32'd1);
    chk("noskip_addr", {24'd0, rom_addr}, 32'h12);
    step();                                  // EXEC
    step();                                  // FETCH
    chk("noskip_exec", {31'd0, mc_exec}, 32'd1);
    chk("noskip_word", {14'd0, mc_word}, 32'h22223);
    chk("noskip_fetch_req", {31'd0, fetch_req}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
